// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the bit-slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single full_adder, LSB first.
// Optional signed-overflow output ovf is enabled with `define SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Operand registers shift right, so the current bit always sits at position 0.
    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    shift_d = {WIDTH{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                shift_d = {fa_s, shift_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // Publish the result only on the last bit; sum never shows partial shifts.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = {fa_s, shift_q[WIDTH-1:1]};
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            shift_q <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed-overflow flag, held alongside sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner sequences, random scoreboard.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Values the outputs must currently hold (last published result, or zero after reset).
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    int           done_cyc;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        int unsigned t;
        int sv;
        t  = int'(x) + int'(y) + int'(ci);
        s  = t[W-1:0];
        co = (t >= 256);
        sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
        ov = (sv > 127) || (sv < -128);
    endfunction

    // Starts an op at the current negedge and follows it to the DONE cycle.
    // inject_k > 0 pulses start with other operands during RUN cycle inject_k.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic eo, input int inject_k);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = ci;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= W) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            if (k == inject_k) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h11;
            end else begin
                start = 1'b0;
            end
            if (k <= W) begin
                check("run_busy", {31'd0, busy}, 32'd1);
                check("run_done", {31'd0, done}, 32'd0);
                check("run_sum_held", {24'd0, sum}, {24'd0, held_sum});
                check("run_cout_held", {31'd0, cout}, {31'd0, held_cout});
            end else begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("done_busy", {31'd0, busy}, 32'd0);
                check("sum", {24'd0, sum}, {24'd0, es});
                check("cout", {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, eo});
`endif
                held_sum  = es;
                held_cout = ec;
                held_ovf  = eo;
                done_cyc  = cyc;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_check(input string nm);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_done"}, {31'd0, done}, 32'd0);
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check({nm, "_sum"}, {24'd0, sum}, {24'd0, held_sum});
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc, ro, rci;
        logic [W-1:0] ra, rb;
        int           d1;

        vt[0]  = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
        vt[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[4]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vt[6]  = '{8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
        vt[7]  = '{8'h00, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0};
        vt[8]  = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vt[9]  = '{8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
        vt[10] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vt[11] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        done_cyc  = 0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        // Vector table, issued back to back.
        for (int i = 0; i < 12; i++) begin
            do_op(vt[i].va, vt[i].vb, vt[i].vcin, vt[i].es, vt[i].ec, vt[i].eo, 0);
        end
        idle_check("idle_after_table");

        // start during RUN is ignored.
        do_op(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 3);
        idle_check("idle_after_inject");

        // start held in DONE: back-to-back, done every W+1 cycles.
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);
        d1 = done_cyc;
        do_op(8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0, 0);
        check("b2b_period", done_cyc - d1, W + 1);
        idle_check("idle_after_b2b");

        // Asynchronous reset in RUN cycle 4 aborts the op.
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h66;
        cin   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);
        idle_check("idle_after_abort");

        // Random scoreboard against integer arithmetic.
        for (int n = 0; n < 1000; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            model(ra, rb, rci, rs, rc, ro);
            do_op(ra, rb, rci, rs, rc, ro, 0);
            if ($urandom_range(0, 3) == 0) idle_check("rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand and result bit count (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled on the rising edge.
REQ-005 The block SHALL have port a, input, WIDTH, first operand; sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH, second operand; sampled only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1, carry-in; sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1, high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH, result of a+b+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1, carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE, encoded as the package enum.
REQ-013 Start accept: start=1 in IDLE or DONE SHALL capture a, b and cin into internal registers, clear the bit counter, and enter RUN.
REQ-014 Start ignored: start=1 in RUN SHALL have no effect, with no capture and no restart.
REQ-015 RUN step: each RUN cycle SHALL add operand bit i and the carry register via one full_adder instance, shift the sum bit into the result register from the MSB side, update the carry register, and increment the counter.
REQ-016 Processing order SHALL be LSB first; after WIDTH RUN cycles the result register holds sum with bit 0 at position 0.
REQ-017 The transition RUN->DONE SHALL occur on the edge that processes bit WIDTH-1.
REQ-018 Latency: done SHALL be high in exactly the cycle that begins WIDTH+1 rising edges after the start-sampling edge, counting that edge as edge 1.
REQ-019 DONE SHALL last one cycle; the next edge goes to RUN if start=1, otherwise to IDLE.
REQ-020 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from inputs.
REQ-021 sum and cout SHALL change only on the edge entering DONE and SHALL hold until the next entry to DONE; intermediate shifts SHALL be hidden behind a separate shift register.
REQ-022 Operands SHALL be unsigned arithmetic; cout=1 exactly when a+b+cin >= 2^WIDTH.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0 and the shift registers to 0, independent of clk.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first rising edge.

Configuration
REQ-025 With SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf, 1 bit, equal to the signed overflow (carry into bit WIDTH-1 XOR cout), updated and held with sum, and reset to 0.
REQ-026 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-027 Package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant SERIAL_ADDER_DEFAULT_WIDTH=8.
REQ-028 The block SHALL instantiate exactly one existing full_adder sub-module (ports a, b, c, s, c_out) as its bit-slice; no other arithmetic operator on operands is permitted.

Verification (WIDTH=8)
REQ-029 Basic add: a=0x03, b=0x05, cin=0, start pulse -> busy high 8 cycles, done on cycle 9, sum=0x08, cout=0.
REQ-030 Wrap-around: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; ovf=0 when SERIAL_ADDER_OVF_EN is defined.
REQ-031 Signed overflow: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 with SERIAL_ADDER_OVF_EN defined; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 Busy start: start reasserted with a=0x11 during RUN -> ignored, first result unchanged; start held high in the DONE cycle -> back-to-back op, done pulses exactly every 9 cycles.
REQ-033 Reset abort: rst_n low on RUN cycle 4 -> outputs 0 asynchronously, no done; a new op after release completes correctly.
REQ-034 Exhaustive check: all 8 (a[0], b[0], cin) combinations with upper bits 0 -> sum and cout match the full-adder truth table; a random 1000-op scoreboard against a+b+cin passes.
